// File: rtl/adc_capture_frontend.sv
// ADC receive front end: offset-binary to signed conversion, optional IIR DC removal,
// and a trigger-plus-delay gated capture window feeding the DDC input.
module adc_capture_frontend #(
  parameter int ADC_W    = 8,
  parameter int OUT_W    = 12,
  parameter int CAP_LEN  = 1024,
  parameter int DC_SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_data_in,
  output logic             adc_clk_out,
  input  logic             trig_in,
  input  logic             arm_in,
  input  logic [15:0]      delay_in,
  input  logic             dc_remove_en,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid_out,
  output logic             frame_start_out,
  output logic             frame_end_out,
  output logic             busy_out,
  output logic [15:0]      overrange_cnt_out,
  output logic [1:0]       state_out
);

  localparam int ACC_W  = OUT_W + DC_SHIFT;
  localparam int PAD_W  = OUT_W - ADC_W;
  localparam int SCNT_W = (CAP_LEN > 1) ? $clog2(CAP_LEN) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DELAY   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [OUT_W:0] v);
    if (v[OUT_W] != v[OUT_W-1])
      return v[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return v[OUT_W-1:0];
  endfunction

  logic [ADC_W-1:0]        adc_p0_q;
  logic signed [OUT_W-1:0] x_p1_q, x_p1_d;
  logic                    clip_p1_q, clip_p1_d;
  logic signed [OUT_W-1:0] sample_p2_q, sample_p2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_shr;
  logic signed [OUT_W-1:0] dc_est;
  logic signed [OUT_W:0]   diff;

  always_comb begin
    // S1 -> S2: flip the offset-binary MSB and left-justify into OUT_W bits
    x_p1_d      = {~adc_p0_q[ADC_W-1], adc_p0_q[ADC_W-2:0], {PAD_W{1'b0}}};
    clip_p1_d   = (adc_p0_q == '0) || (adc_p0_q == '1);
    acc_shr     = acc_q >>> DC_SHIFT;
    dc_est      = acc_shr[OUT_W-1:0];
    acc_d       = acc_q + {{DC_SHIFT{x_p1_q[OUT_W-1]}}, x_p1_q} - acc_shr;
    // S2 -> S3: output select and DC subtraction
    diff        = {x_p1_q[OUT_W-1], x_p1_q} - {dc_est[OUT_W-1], dc_est};
    sample_p2_d = dc_remove_en ? sat_out(diff) : x_p1_q;
  end

  // S1 resets to mid-scale so the cleared pipeline carries a true zero sample
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_p0_q    <= {1'b1, {(ADC_W-1){1'b0}}};
      x_p1_q      <= '0;
      clip_p1_q   <= 1'b0;
      sample_p2_q <= '0;
      acc_q       <= '0;
    end else begin
      adc_p0_q    <= adc_data_in;
      x_p1_q      <= x_p1_d;
      clip_p1_q   <= clip_p1_d;
      sample_p2_q <= sample_p2_d;
      acc_q       <= acc_d;
    end
  end

  logic [2:0]        trig_sync_q;
  logic              trig_edge;
  state_t            state_q;
  logic [15:0]       dcnt_q;
  logic [SCNT_W-1:0] scnt_q;
  logic              vld_p2_q, fs_p2_q, fe_p2_q;
  logic [15:0]       ovr_q;

  assign trig_edge = trig_sync_q[1] & ~trig_sync_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_sync_q <= '0;
      state_q     <= IDLE;
      dcnt_q      <= '0;
      scnt_q      <= '0;
      vld_p2_q    <= 1'b0;
      fs_p2_q     <= 1'b0;
      fe_p2_q     <= 1'b0;
      ovr_q       <= '0;
    end else begin
      trig_sync_q <= {trig_sync_q[1:0], trig_in};
      vld_p2_q    <= (state_q == CAPTURE);
      fs_p2_q     <= (state_q == CAPTURE) && (scnt_q == '0);
      fe_p2_q     <= (state_q == CAPTURE) && (scnt_q == SCNT_LAST);
      if ((state_q == CAPTURE) && clip_p1_q && (ovr_q != 16'hFFFF))
        ovr_q <= ovr_q + 16'd1;
      case (state_q)
        IDLE: if (arm_in) state_q <= ARMED;
        ARMED: begin
          if (!arm_in) begin
            state_q <= IDLE;
          end else if (trig_edge) begin
            ovr_q   <= '0;
            dcnt_q  <= delay_in;
            scnt_q  <= '0;
            state_q <= (delay_in == 16'd0) ? CAPTURE : DELAY;
          end
        end
        DELAY: begin
          if (dcnt_q == 16'd1) state_q <= CAPTURE;
          else                 dcnt_q  <= dcnt_q - 16'd1;
        end
        CAPTURE: begin
          if (scnt_q == SCNT_LAST) begin
            scnt_q  <= '0;
            state_q <= arm_in ? ARMED : IDLE;
          end else begin
            scnt_q <= scnt_q + SCNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_clk_out       = clk;
  assign sample_out        = sample_p2_q;
  assign sample_valid_out  = vld_p2_q;
  assign frame_start_out   = fs_p2_q;
  assign frame_end_out     = fe_p2_q;
  assign busy_out          = (state_q != IDLE);
  assign overrange_cnt_out = ovr_q;
  assign state_out         = state_q;

endmodule

// File: tb/tb_adc_capture_frontend.sv
// Randomized bench for adc_capture_frontend against a timeline-based reference model.
module tb_adc_capture_frontend;

  localparam int CAP = 16;
  localparam int DCS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adc = 8'h80;
  logic        trig = 1'b0;
  logic        arm = 1'b0;
  logic [15:0] dly = 16'd0;
  logic        dcen = 1'b0;

  logic        adc_clk_out;
  logic [11:0] sample_out;
  logic        sample_valid_out, frame_start_out, frame_end_out, busy_out;
  logic [15:0] overrange_cnt_out;
  logic [1:0]  state_out;

  adc_capture_frontend #(
    .ADC_W(8), .OUT_W(12), .CAP_LEN(CAP), .DC_SHIFT(DCS)
  ) dut (
    .clk(clk), .rst(rst), .adc_data_in(adc), .adc_clk_out(adc_clk_out),
    .trig_in(trig), .arm_in(arm), .delay_in(dly), .dc_remove_en(dcen),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .frame_start_out(frame_start_out), .frame_end_out(frame_end_out),
    .busy_out(busy_out), .overrange_cnt_out(overrange_cnt_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=armed 2=window scheduled/running between edges
  int m_n = 0, m_phase = 0, m_start = 0, m_end = 0, m_acc = 0, m_ovr = 0;
  int ph0 = 128, ph1 = 128;
  bit th0 = 0, th1 = 0, th2 = 0;
  int e_sample = 0, e_ovr = 0, e_state = 0;
  bit e_valid = 0, e_fs = 0, e_fe = 0, e_busy = 0;

  function automatic int conv(input int a);
    int s;
    s = a ^ 128;
    if (s >= 128) s -= 256;
    return s * 16;
  endfunction

  function automatic int sat12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_edge();
    bit tedge, prev_cap;
    int xk, est;
    m_n++;
    if (rst) begin
      m_phase = 0; m_acc = 0; m_ovr = 0;
      ph0 = 128; ph1 = 128; th0 = 0; th1 = 0; th2 = 0;
      e_sample = 0; e_valid = 0; e_fs = 0; e_fe = 0; e_busy = 0; e_ovr = 0; e_state = 0;
      return;
    end
    tedge    = th1 & ~th2;
    prev_cap = (m_phase == 2) && (m_n - 1 >= m_start) && (m_n - 1 < m_end);
    e_valid  = prev_cap;
    e_fs     = prev_cap && (m_n - 1 == m_start);
    e_fe     = prev_cap && (m_n - 1 == m_end - 1);
    xk       = conv(ph1);
    est      = m_acc >>> DCS;
    e_sample = dcen ? sat12(xk - est) : xk;
    m_acc    = m_acc + xk - est;
    if (prev_cap && (ph1 == 0 || ph1 == 255) && m_ovr < 65535) m_ovr++;
    case (m_phase)
      0: if (arm) m_phase = 1;
      1: begin
        if (!arm) m_phase = 0;
        else if (tedge) begin
          m_start = m_n + int'(dly);
          m_end   = m_start + CAP;
          m_phase = 2;
          m_ovr   = 0;
        end
      end
      default: if (m_n == m_end) m_phase = arm ? 1 : 0;
    endcase
    e_ovr   = m_ovr;
    e_busy  = (m_phase != 0);
    e_state = (m_phase == 2) ? ((m_n < m_start) ? 2 : 3) : m_phase;
    th2 = th1; th1 = th0; th0 = trig;
    ph1 = ph0; ph0 = int'(adc);
  endtask

  bit adc_rand = 0;
  int vcnt = 0, fscnt = 0, fecnt = 0;

  function automatic logic [7:0] rand_adc();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic tick();
    if (adc_rand) adc = rand_adc();
    model_edge();
    @(posedge clk);
    #1 check_val("adc_clk_hi", int'(adc_clk_out), 1);
    @(negedge clk);
    check_val("adc_clk_lo", int'(adc_clk_out), 0);
    check_val("sample", int'($signed(sample_out)), e_sample);
    check_val("valid", int'(sample_valid_out), int'(e_valid));
    check_val("frame_start", int'(frame_start_out), int'(e_fs));
    check_val("frame_end", int'(frame_end_out), int'(e_fe));
    check_val("busy", int'(busy_out), int'(e_busy));
    check_val("ovr_cnt", int'(overrange_cnt_out), e_ovr);
    check_val("state", int'(state_out), e_state);
    if (sample_valid_out === 1'b1) vcnt++;
    if (frame_start_out === 1'b1) fscnt++;
    if (frame_end_out === 1'b1) fecnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    vcnt = 0; fscnt = 0; fecnt = 0;
  endtask

  task automatic check_window(input string tag);
    check_val({tag, "_len"}, vcnt, CAP);
    check_val({tag, "_fs"}, fscnt, 1);
    check_val({tag, "_fe"}, fecnt, 1);
  endtask

  logic [7:0] fmt_in [4] = '{8'h80, 8'hFF, 8'h00, 8'h81};
  int         fmt_exp[4] = '{0, 2032, -2048, 16};
  logic [7:0] ovr_pat[16] = '{8'h80, 8'h40, 8'hFF, 8'h80, 8'h10, 8'hFF, 8'h80, 8'h90,
                              8'h80, 8'hFF, 8'h70, 8'h00, 8'h80, 8'h00, 8'h80, 8'h80};

  initial begin
    int s;
    // Reset state
    rst = 1'b1;
    run(3);
    check_val("rst_state", int'(state_out), 0);
    check_val("rst_sample", int'(sample_out), 0);
    rst = 1'b0;

    // Format conversion, three-cycle pin-to-output latency
    dcen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc = fmt_in[i];
      run(3);
      check_val("fmt", int'($signed(sample_out)), fmt_exp[i]);
    end

    // Window with delay 5, then delay 0
    adc_rand = 1;
    arm = 1'b1; dly = 16'd5;
    tick();
    clr_counts();
    trig = 1'b1; run(2); trig = 1'b0;
    run(40);
    check_window("win_d5");
    dly = 16'd0;
    clr_counts();
    trig = 1'b1; run(2); trig = 1'b0;
    run(30);
    check_window("win_d0");

    // Retriggers during DELAY/CAPTURE are ignored; arm drop lets the window finish
    dly = 16'd3;
    clr_counts();
    trig = 1'b1; run(2); trig = 1'b0;
    run(4);
    trig = 1'b1; tick(); trig = 1'b0;
    run(8);
    trig = 1'b1; tick(); trig = 1'b0;
    arm = 1'b0;
    run(30);
    check_window("win_retrig");
    check_val("idle_after_disarm", int'(state_out), 0);

    // Arm held high: back in ARMED and a new trigger captures again
    arm = 1'b1; dly = 16'd1;
    tick();
    clr_counts();
    trig = 1'b1; tick(); trig = 1'b0;
    run(25);
    check_window("win_rearm");
    check_val("armed_after", int'(state_out), 1);

    // DC removal on a constant 0x90 input
    adc_rand = 0; adc = 8'h90; dcen = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    run(3);
    check_val("dc_first", int'($signed(sample_out)), 256);
    run(8 * 64);
    s = int'($signed(sample_out));
    check_val("dc_settled", int'(s >= -1 && s <= 1), 1);
    dcen = 1'b0;
    tick();
    check_val("dc_off", int'($signed(sample_out)), 256);

    // Overrange count over one window, then cleared by the next trigger
    adc = 8'h80;
    rst = 1'b1; tick(); rst = 1'b0;
    arm = 1'b1; dly = 16'd0;
    run(4);
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < 16; i++) begin
      adc = ovr_pat[i];
      tick();
    end
    adc = 8'h80;
    run(5);
    check_val("ovr_five", int'(overrange_cnt_out), 5);
    trig = 1'b1; tick(); trig = 1'b0;
    run(2);
    check_val("ovr_clear", int'(overrange_cnt_out), 0);
    run(20);

    // Reset in the middle of a capture window
    adc_rand = 1; dly = 16'd2;
    clr_counts();
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < 50 && vcnt < 7; i++) tick();
    check_val("mid_reached", vcnt, 7);
    clr_counts();
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("mid_rst_state", int'(state_out), 0);
    check_val("mid_rst_valid", int'(sample_valid_out), 0);
    check_val("mid_rst_fe", fecnt, 0);
    run(2);
    clr_counts();
    trig = 1'b1; tick(); trig = 1'b0;
    run(25);
    check_window("win_after_rst");

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 999) == 0);
      arm  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) trig = ~trig;
      if ($urandom_range(0, 63) == 0) dcen = ~dcen;
      dly  = 16'($urandom_range(0, 6));
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
